// File: rtl/prog_launcher.sv
// Start/Done run-protocol initiator: pulses Start per program, times each run, flags sequence end.
// Optional watchdog on the RUN phase is enabled by defining LAUNCH_TIMEOUT_EN.
module prog_launcher #(
  parameter int unsigned NUM_PROGS  = 3,
  parameter int unsigned START_HIGH = 2,
  parameter int unsigned GAP        = 2,
  parameter int unsigned CW         = 16,
  parameter int unsigned TIMEOUT    = 4096
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Go,
  input  logic          Done,
  output logic          Start,
  output logic [1:0]    ProgIdx,
  output logic          Busy,
  output logic [CW-1:0] CycleCnt,
  output logic          CntValid,
  output logic          AllDone,
  output logic          TimedOut
);

  localparam int unsigned HW = (START_HIGH > 1) ? $clog2(START_HIGH) : 1;
  localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;

  // Elaboration-time parameter sanity checks
  if (NUM_PROGS < 1 || NUM_PROGS > 3) begin : g_bad_num_progs
    $error("prog_launcher: NUM_PROGS must be 1..3");
  end
  if (START_HIGH < 1) begin : g_bad_start_high
    $error("prog_launcher: START_HIGH must be >= 1");
  end
  if (TIMEOUT == 0 || (CW < 32 && TIMEOUT >= (32'd1 << CW))) begin : g_bad_timeout
    $error("prog_launcher: TIMEOUT must be 1..2**CW-1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ASSERT,
    S_RUN,
    S_GAP,
    S_FINISH
  } state_t;

  state_t        state, state_n;
  logic [HW-1:0] hold_cnt, hold_n;
  logic [GW-1:0] gap_cnt, gap_n;
  logic [CW-1:0] run_cnt, run_n;
  logic          start_n, busy_n, valid_n, all_done_n, timed_n;
  logic [1:0]    prog_n;
  logic [CW-1:0] cnt_n;
  logic          launch;
  logic [1:0]    launch_idx;

  // State and registered outputs
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= S_IDLE;
      hold_cnt <= '0;
      gap_cnt  <= '0;
      run_cnt  <= '0;
      Start    <= 1'b0;
      ProgIdx  <= 2'd0;
      Busy     <= 1'b0;
      CycleCnt <= '0;
      CntValid <= 1'b0;
      AllDone  <= 1'b0;
      TimedOut <= 1'b0;
    end else begin
      state    <= state_n;
      hold_cnt <= hold_n;
      gap_cnt  <= gap_n;
      run_cnt  <= run_n;
      Start    <= start_n;
      ProgIdx  <= prog_n;
      Busy     <= busy_n;
      CycleCnt <= cnt_n;
      CntValid <= valid_n;
      AllDone  <= all_done_n;
      TimedOut <= timed_n;
    end
  end

  // Next state and next output values
  always_comb begin
    state_n    = state;
    hold_n     = hold_cnt;
    gap_n      = gap_cnt;
    run_n      = run_cnt;
    start_n    = Start;
    prog_n     = ProgIdx;
    cnt_n      = CycleCnt;
    valid_n    = 1'b0;
    timed_n    = TimedOut;
    launch     = 1'b0;
    launch_idx = ProgIdx;

    unique case (state)
      S_IDLE, S_FINISH: begin
        if (Go) begin
          launch     = 1'b1;
          launch_idx = 2'd1;
          timed_n    = 1'b0;
        end
      end
      S_ASSERT: begin
        if (hold_cnt == HW'(START_HIGH - 1)) begin
          state_n = S_RUN;
          start_n = 1'b0;
          run_n   = '0;
        end else begin
          hold_n = hold_cnt + 1'b1;
        end
      end
      S_RUN: begin
        if (Done) begin
          cnt_n   = run_cnt;
          valid_n = 1'b1;
          if (ProgIdx == 2'(NUM_PROGS)) begin
            state_n = S_FINISH;
          end else if (GAP == 0) begin
            launch     = 1'b1;
            launch_idx = ProgIdx + 2'd1;
          end else begin
            state_n = S_GAP;
            gap_n   = '0;
          end
        end else begin
          if (run_cnt != '1) begin
            run_n = run_cnt + 1'b1;
          end
`ifdef LAUNCH_TIMEOUT_EN
          // This cycle is the TIMEOUT-th without Done: abandon the sequence
          if (run_cnt == CW'(TIMEOUT - 1)) begin
            timed_n = 1'b1;
            cnt_n   = CW'(TIMEOUT);
            valid_n = 1'b1;
            state_n = S_FINISH;
          end
`endif
        end
      end
      S_GAP: begin
        if (gap_cnt == GW'(GAP - 1)) begin
          launch     = 1'b1;
          launch_idx = ProgIdx + 2'd1;
        end else begin
          gap_n = gap_cnt + 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (launch) begin
      state_n = S_ASSERT;
      start_n = 1'b1;
      prog_n  = launch_idx;
      hold_n  = '0;
    end

    busy_n     = (state_n == S_ASSERT) || (state_n == S_RUN) || (state_n == S_GAP);
    all_done_n = (state_n == S_FINISH);
  end

endmodule

// File: tb/tb_prog_launcher.sv
// Bench for prog_launcher: cycle-level expectation model plus directed scenarios.
`timescale 1ns/1ps
module tb_prog_launcher;

  localparam int unsigned NUM_PROGS  = 3;
  localparam int unsigned START_HIGH = 2;
  localparam int unsigned GAP        = 2;
  localparam int unsigned CW         = 16;
  localparam int unsigned TIMEOUT    = 50;
  localparam int          CNT_MAX    = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          go = 1'b0;
  logic          done = 1'b0;
  logic          start;
  logic [1:0]    prog_idx;
  logic          busy;
  logic [CW-1:0] cycle_cnt;
  logic          cnt_valid;
  logic          all_done;
  logic          timed_out;

  int checks = 0;
  int errors = 0;
  bit armed  = 1'b0;

  always #5 clk = ~clk;

  prog_launcher #(
    .NUM_PROGS (NUM_PROGS),
    .START_HIGH(START_HIGH),
    .GAP       (GAP),
    .CW        (CW),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .Clk     (clk),
    .Reset   (reset),
    .Go      (go),
    .Done    (done),
    .Start   (start),
    .ProgIdx (prog_idx),
    .Busy    (busy),
    .CycleCnt(cycle_cnt),
    .CntValid(cnt_valid),
    .AllDone (all_done),
    .TimedOut(timed_out)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expectation model: countdowns for the high and gap phases, a flag for the run phase
  int m_prog, m_hold, m_run, m_gap_left, m_cnt;
  bit m_start, m_running, m_in_gap, m_finish, m_valid, m_to;

  task automatic m_launch(input int p);
    m_prog  = p;
    m_start = 1'b1;
    m_hold  = START_HIGH;
  endtask

  initial begin
    {m_prog, m_hold, m_run, m_gap_left, m_cnt} = '0;
    {m_start, m_running, m_in_gap, m_finish, m_valid, m_to} = '0;
    forever begin
      @(posedge clk);
      m_valid = 1'b0;
      if (reset) begin
        {m_prog, m_hold, m_run, m_gap_left, m_cnt} = '0;
        {m_start, m_running, m_in_gap, m_finish, m_to} = '0;
      end else if (m_start) begin
        m_hold--;
        if (m_hold == 0) begin
          m_start   = 1'b0;
          m_running = 1'b1;
          m_run     = 0;
        end
      end else if (m_running) begin
        if (done) begin
          m_cnt     = m_run;
          m_valid   = 1'b1;
          m_running = 1'b0;
          if (m_prog == NUM_PROGS) m_finish = 1'b1;
          else if (GAP == 0) m_launch(m_prog + 1);
          else begin
            m_in_gap   = 1'b1;
            m_gap_left = GAP;
          end
        end else begin
          m_run = (m_run < CNT_MAX) ? m_run + 1 : CNT_MAX;
`ifdef LAUNCH_TIMEOUT_EN
          if (m_run == TIMEOUT) begin
            m_to      = 1'b1;
            m_cnt     = TIMEOUT;
            m_valid   = 1'b1;
            m_running = 1'b0;
            m_finish  = 1'b1;
          end
`endif
        end
      end else if (m_in_gap) begin
        m_gap_left--;
        if (m_gap_left == 0) begin
          m_in_gap = 1'b0;
          m_launch(m_prog + 1);
        end
      end else if (go) begin
        m_finish = 1'b0;
        m_to     = 1'b0;
        m_launch(1);
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the model
  initial forever begin
    @(negedge clk);
    if (armed) begin
      chk("start", 32'(start), 32'(m_start));
      chk("prog_idx", 32'(prog_idx), m_prog);
      chk("busy", 32'(busy), 32'(m_start || m_running || m_in_gap));
      chk("cycle_cnt", 32'(cycle_cnt), m_cnt);
      chk("cnt_valid", 32'(cnt_valid), 32'(m_valid));
      chk("all_done", 32'(all_done), 32'(m_finish));
      chk("timed_out", 32'(timed_out), 32'(m_to));
    end
  end

  // Record reported cycle counts and Start rises
  int vq[$];
  int rises = 0;
  bit prev_start = 1'b0;
  initial forever begin
    @(posedge clk);
    if (cnt_valid === 1'b1) vq.push_back(int'(cycle_cnt));
    if (start === 1'b1 && !prev_start) rises++;
    prev_start = (start === 1'b1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic int vq_at(input int i);
    if (i < vq.size()) return vq[i];
    return -1;
  endfunction

  task automatic wait_fall();
    int t = 0;
    while (start !== 1'b1 && t < 100) begin tick(); t++; end
    while (start !== 1'b0 && t < 100) begin tick(); t++; end
    chk("start_fall_within_bound", 32'(t < 100), 32'd1);
  endtask

  task automatic run_prog(input int n);
    wait_fall();
    done = 1'b0;
    repeat (n) tick();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  task automatic go_pulse();
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  initial begin
    int h, lows;
    // 1: reset then idle
    reset = 1'b1;
    repeat (2) tick();
    armed = 1'b1;
    reset = 1'b0;
    repeat (20) tick();
    chk("t1_start", 32'(start), 32'd0);
    chk("t1_prog_idx", 32'(prog_idx), 32'd0);
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_all_done", 32'(all_done), 32'd0);

    // 2: Start width, count of 9, low time before next launch
    vq.delete();
    go_pulse();
    chk("t2_start_rise", 32'(start), 32'd1);
    chk("t2_prog1", 32'(prog_idx), 32'd1);
    h = 0;
    while (start === 1'b1 && h < 20) begin h++; tick(); end
    chk("t2_high_cycles", h, 2);
    repeat (9) tick();
    done = 1'b1;
    lows = 1;
    tick();
    done = 1'b0;
    while (start === 1'b0 && lows < 20) begin lows++; tick(); end
    chk("t2_low_cycles", lows, 3);
    chk("t2_prog2", 32'(prog_idx), 32'd2);
    chk("t2_cnt9", vq_at(0), 9);
    run_prog(4);
    run_prog(4);
    tick();
    chk("t2_all_done", 32'(all_done), 32'd1);
    chk("t2_prog_hold", 32'(prog_idx), 32'd3);

    // 3: full sequence 5/7/9 from FINISH
    vq.delete();
    rises = 0;
    go_pulse();
    chk("t3_restart_prog1", 32'(prog_idx), 32'd1);
    chk("t3_all_done_clr", 32'(all_done), 32'd0);
    run_prog(5);
    run_prog(7);
    run_prog(9);
    tick();
    chk("t3_nvalid", vq.size(), 3);
    chk("t3_cnt_a", vq_at(0), 5);
    chk("t3_cnt_b", vq_at(1), 7);
    chk("t3_cnt_c", vq_at(2), 9);
    chk("t3_rises", rises, 3);
    chk("t3_all_done", 32'(all_done), 32'd1);
    chk("t3_busy", 32'(busy), 32'd0);

    // 4: held Done ignored outside RUN, Done in first RUN cycle, Go during RUN
    vq.delete();
    go_pulse();
    wait_fall();
    repeat (3) tick();
    done = 1'b1;
    wait_fall();
    tick();
    done = 1'b0;
    wait_fall();
    go = 1'b1;
    repeat (4) tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    go = 1'b0;
    tick();
    chk("t4_cnt_a", vq_at(0), 3);
    chk("t4_cnt_first_cycle", vq_at(1), 0);
    chk("t4_cnt_go_ignored", vq_at(2), 4);
    chk("t4_all_done", 32'(all_done), 32'd1);

    // 5: reset during program 2
    go_pulse();
    run_prog(3);
    wait_fall();
    repeat (2) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_start", 32'(start), 32'd0);
    chk("t5_prog_idx", 32'(prog_idx), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_cycle_cnt", 32'(cycle_cnt), 32'd0);
    go_pulse();
    chk("t5_restart_prog1", 32'(prog_idx), 32'd1);
    chk("t5_restart_start", 32'(start), 32'd1);
    run_prog(2);
    run_prog(2);
    run_prog(2);
    tick();
    chk("t5_all_done", 32'(all_done), 32'd1);

    // 6: Done never arrives
    go_pulse();
    wait_fall();
    done = 1'b0;
`ifdef LAUNCH_TIMEOUT_EN
    repeat (TIMEOUT - 1) tick();
    chk("t6_not_yet", 32'(timed_out), 32'd0);
    tick();
    chk("t6_timed_out", 32'(timed_out), 32'd1);
    chk("t6_cnt", 32'(cycle_cnt), TIMEOUT);
    chk("t6_valid", 32'(cnt_valid), 32'd1);
    chk("t6_all_done", 32'(all_done), 32'd1);
    chk("t6_prog_idx", 32'(prog_idx), 32'd1);
    tick();
    go_pulse();
    chk("t6_to_cleared", 32'(timed_out), 32'd0);
    chk("t6_restart_prog1", 32'(prog_idx), 32'd1);
`else
    repeat (200) tick();
    chk("t6_still_busy", 32'(busy), 32'd1);
    chk("t6_no_all_done", 32'(all_done), 32'd0);
    chk("t6_no_timeout", 32'(timed_out), 32'd0);
    chk("t6_start_low", 32'(start), 32'd0);
`endif
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule
